// File: rtl/cos_sched_pkg.sv
// Shared types and widths for the cosine-unit scheduler.
// The state encoding and operand/result widths match the coss unit interface.
package cos_sched_pkg;

  localparam int X_W    = 10;
  localparam int Y_W    = 8;
  localparam int INT_W  = 2;
  localparam int FRAC_W = 8;
  localparam int GID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, searching cyclically.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    // Walk from the farthest offset back to ptr so the nearest pending requester wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt                          = '0;
        gnt[(int'(ptr) + k) % N]     = 1'b1;
        gnt_idx                      = PTR_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/cos_scheduler.sv
// Round-robin scheduler sharing one coss cosine unit between N requesters,
// with a start pulse sequencer, stale-done rejection and a timeout watchdog.
//
// state | meaning
// IDLE  | nothing in flight; arbitrate and latch operands of the winner
// START | cos_start held high for START_CYCLES cycles
// WAIT  | wait for a fresh cos_done or the watchdog reaching TIMEOUT
// RESP  | one-cycle ack to the granted requester with the captured result
module cos_scheduler
  import cos_sched_pkg::*;
#(
  parameter int N            = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*X_W-1:0]    req_x,
  input  logic [N*Y_W-1:0]    req_y,
  output logic [N-1:0]        ack,
  output logic [INT_W-1:0]    res_int,
  output logic [FRAC_W-1:0]   res_frac,
  output logic                res_err,
  output logic                busy,
  output logic [GID_W-1:0]    grant_id,
  output logic                cos_start,
  output logic [X_W-1:0]      cos_x,
  output logic [Y_W-1:0]      cos_y,
  input  logic                cos_done,
  input  logic [INT_W-1:0]    cos_intpart,
  input  logic [FRAC_W-1:0]   cos_fracpart
);

  localparam int PTR_W = $clog2(N);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N-1:0]        gnt_oh_q, gnt_oh_d;
  logic [GID_W-1:0]    grant_id_q, grant_id_d;
  logic [X_W-1:0]      cos_x_q, cos_x_d;
  logic [Y_W-1:0]      cos_y_q, cos_y_d;
  logic                cos_start_q, cos_start_d;
  logic [SC_W-1:0]     start_cnt_q, start_cnt_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                seen_low_q, seen_low_d;
  logic [N-1:0]        ack_q, ack_d;
  logic [INT_W-1:0]    res_int_q, res_int_d;
  logic [FRAC_W-1:0]   res_frac_q, res_frac_d;
  logic                res_err_q, res_err_d;
  logic                busy_q, busy_d;

  logic [N-1:0]        arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(.N(N), .PTR_W(PTR_W)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_oh_d    = gnt_oh_q;
    grant_id_d  = grant_id_q;
    cos_x_d     = cos_x_q;
    cos_y_d     = cos_y_q;
    cos_start_d = 1'b0;
    start_cnt_d = start_cnt_q;
    wdog_d      = wdog_q;
    seen_low_d  = seen_low_q;
    ack_d       = '0;
    res_int_d   = res_int_q;
    res_frac_d  = res_frac_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d     = START;
          gnt_oh_d    = arb_gnt;
          grant_id_d  = GID_W'(arb_idx);
          cos_x_d     = req_x[arb_idx*X_W +: X_W];
          cos_y_d     = req_y[arb_idx*Y_W +: Y_W];
          rr_ptr_d    = (arb_idx == PTR_W'(N - 1)) ? '0 : arb_idx + 1'b1;
          start_cnt_d = SC_W'(START_CYCLES - 1);
          cos_start_d = 1'b1;
        end
      end
      START: begin
        if (start_cnt_q == '0) begin
          state_d    = WAIT;
          wdog_d     = '0;
          seen_low_d = 1'b0;
        end else begin
          start_cnt_d = start_cnt_q - 1'b1;
          cos_start_d = 1'b1;
        end
      end
      WAIT: begin
        // A done level is only trusted once it has been seen low in this operation.
        seen_low_d = seen_low_q | ~cos_done;
        wdog_d     = (wdog_q == WD_W'(TIMEOUT)) ? wdog_q : wdog_q + 1'b1;
        if (seen_low_q && cos_done) begin
          state_d    = RESP;
          res_int_d  = cos_intpart;
          res_frac_d = cos_fracpart;
          res_err_d  = 1'b0;
          ack_d      = gnt_oh_q;
        end else if (wdog_q == WD_W'(TIMEOUT)) begin
          state_d    = RESP;
          res_int_d  = '0;
          res_frac_d = '0;
          res_err_d  = 1'b1;
          ack_d      = gnt_oh_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_oh_q    <= '0;
      grant_id_q  <= '0;
      cos_x_q     <= '0;
      cos_y_q     <= '0;
      cos_start_q <= 1'b0;
      start_cnt_q <= '0;
      wdog_q      <= '0;
      seen_low_q  <= 1'b0;
      ack_q       <= '0;
      res_int_q   <= '0;
      res_frac_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_oh_q    <= gnt_oh_d;
      grant_id_q  <= grant_id_d;
      cos_x_q     <= cos_x_d;
      cos_y_q     <= cos_y_d;
      cos_start_q <= cos_start_d;
      start_cnt_q <= start_cnt_d;
      wdog_q      <= wdog_d;
      seen_low_q  <= seen_low_d;
      ack_q       <= ack_d;
      res_int_q   <= res_int_d;
      res_frac_q  <= res_frac_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign res_int   = res_int_q;
  assign res_frac  = res_frac_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign cos_start = cos_start_q;
  assign cos_x     = cos_x_q;
  assign cos_y     = cos_y_q;

endmodule

// File: tb/tb_cos_scheduler.sv
// Directed bench for cos_scheduler: vector table for grant order, results, latency
// and timeout, plus sequences for stale done, reset mid-WAIT and operand stability.
module tb_cos_scheduler;

  localparam int N  = 4;
  localparam int SC = 2;
  localparam int TO = 1023;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*10-1:0] req_x;
  logic [N*8-1:0]  req_y;
  logic [N-1:0]    ack;
  logic [1:0]      res_int;
  logic [7:0]      res_frac;
  logic            res_err;
  logic            busy;
  logic [2:0]      grant_id;
  logic            cos_start;
  logic [9:0]      cos_x;
  logic [7:0]      cos_y;
  logic            cos_done;
  logic [1:0]      cos_intpart;
  logic [7:0]      cos_fracpart;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cos_scheduler #(.N(N), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
    .ack(ack), .res_int(res_int), .res_frac(res_frac), .res_err(res_err),
    .busy(busy), .grant_id(grant_id), .cos_start(cos_start),
    .cos_x(cos_x), .cos_y(cos_y), .cos_done(cos_done),
    .cos_intpart(cos_intpart), .cos_fracpart(cos_fracpart)
  );

  // coss stub: one-cycle done pulse stub_delay cycles after cos_start falls.
  logic       start_d1 = 1'b0;
  logic       stub_done_r = 1'b0;
  logic       stub_arm = 1'b0;
  int         stub_cnt = 0;
  int         stub_delay = -1;
  logic [1:0] stub_int = '0;
  logic [7:0] stub_frac = '0;
  logic       man_mode = 1'b0;
  logic       man_done = 1'b0;

  always @(negedge clk) begin
    if (start_d1 && !cos_start) begin
      stub_cnt    <= 0;
      stub_arm    <= 1'b1;
      stub_done_r <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_arm && stub_delay > 0 && stub_cnt + 1 == stub_delay) begin
        stub_done_r <= 1'b1;
        stub_arm    <= 1'b0;
      end else begin
        stub_done_r <= 1'b0;
      end
    end
    start_d1 <= cos_start;
  end

  assign cos_done     = man_mode ? man_done : stub_done_r;
  assign cos_intpart  = stub_int;
  assign cos_fracpart = stub_frac;

  logic [9:0] opx [N];
  logic [7:0] opy [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      req_x[10*i +: 10] = opx[i];
      req_y[8*i +: 8]   = opy[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},       32'(ack), 0);
    check({tag, "_res_int"},   32'(res_int), 0);
    check({tag, "_res_frac"},  32'(res_frac), 0);
    check({tag, "_res_err"},   32'(res_err), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_grant_id"},  32'(grant_id), 0);
    check({tag, "_cos_start"}, 32'(cos_start), 0);
    check({tag, "_cos_x"},     32'(cos_x), 0);
    check({tag, "_cos_y"},     32'(cos_y), 0);
  endtask

  // Wait for an ack; lat = cycles from WAIT entry to ack, nstart = cos_start-high cycles.
  task automatic wait_ack(input int budget, output int lat, output int nstart, output logic ok);
    int wait_at;
    wait_at = -1;
    nstart  = 0;
    lat     = -1;
    ok      = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (cos_start) nstart++;
      else if (nstart > 0 && wait_at < 0) wait_at = c;
      if (ack != '0) begin
        check("ack_onehot", 32'($countones(ack)), 1);
        ok  = 1'b1;
        lat = c - wait_at;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout got no ack expected ack within %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic       do_rst;
    logic [3:0] add;
    int         delay;
    logic [1:0] ri;
    logic [7:0] rf;
    int         gid;
  } vec_t;

  vec_t tv [8];

  initial begin
    int         lat, ns, wh, early, unstable;
    logic       ok, s, seen;
    logic [3:0] ea;
    logic [9:0] hx;
    logic [7:0] hy;

    opx[0] = 10'h001; opy[0] = 8'h10;
    opx[1] = 10'b0110000000; opy[1] = 8'b10000000;
    opx[2] = 10'h2AA; opy[2] = 8'h55;
    opx[3] = 10'h3FF; opy[3] = 8'hC3;
    load_ops();

    tv[0] = '{1'b0, 4'b0010, 20, 2'b00, 8'h80, 1};
    tv[1] = '{1'b1, 4'b1111,  3, 2'b01, 8'h11, 0};
    tv[2] = '{1'b0, 4'b0000,  1, 2'b10, 8'h22, 1};
    tv[3] = '{1'b0, 4'b0000,  5, 2'b11, 8'h33, 2};
    tv[4] = '{1'b0, 4'b0000,  2, 2'b00, 8'h44, 3};
    tv[5] = '{1'b0, 4'b0001,  4, 2'b01, 8'h55, 0};
    tv[6] = '{1'b0, 4'b0100, -1, 2'b11, 8'hFF, 2};
    tv[7] = '{1'b0, 4'b1000,  6, 2'b10, 8'h66, 3};

    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (tv[i].do_rst) begin
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
      end
      stub_delay = tv[i].delay;
      stub_int   = tv[i].ri;
      stub_frac  = tv[i].rf;
      req        = req | tv[i].add;
      wait_ack(TO + 100, lat, ns, ok);
      if (ok) begin
        ea = '0;
        ea[tv[i].gid] = 1'b1;
        check("vec_ack",      32'(ack), 32'(ea));
        check("vec_grant_id", 32'(grant_id), 32'(tv[i].gid));
        check("vec_res_int",  32'(res_int),  (tv[i].delay < 0) ? 0 : 32'(tv[i].ri));
        check("vec_res_frac", 32'(res_frac), (tv[i].delay < 0) ? 0 : 32'(tv[i].rf));
        check("vec_res_err",  32'(res_err),  (tv[i].delay < 0) ? 1 : 0);
        check("vec_latency",  32'(lat), (tv[i].delay < 0) ? 32'(TO + 1) : 32'(tv[i].delay + 1));
        check("vec_start_cycles", 32'(ns), 32'(SC));
        check("vec_cos_x",    32'(cos_x), 32'(opx[tv[i].gid]));
        check("vec_cos_y",    32'(cos_y), 32'(opy[tv[i].gid]));
        check("vec_busy_resp", 32'(busy), 1);
        req = req & ~ack;
        @(negedge clk);
        check("vec_ack_one_cycle", 32'(ack), 0);
        check("vec_idle_gap_busy", 32'(busy), 0);
      end
    end

    // Stale done: done held high through START into WAIT, dropped once, raised again.
    stub_int  = 2'b01;
    stub_frac = 8'h3C;
    man_done  = 1'b1;
    man_mode  = 1'b1;
    req       = 4'b0001;
    wh = 0; early = 0; s = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack != '0) early++;
      if (cos_start) s = 1'b1;
      else if (s) begin
        wh++;
        if (wh == 3) break;
      end
    end
    check("stale_wait_reached", 32'(wh), 3);
    check("stale_no_early_ack", 32'(early), 0);
    man_done = 1'b0;
    @(negedge clk);
    check("stale_no_ack_on_low", 32'(ack), 0);
    man_done = 1'b1;
    @(negedge clk);
    check("stale_ack", 32'(ack), 32'h1);
    check("stale_res_int", 32'(res_int), 32'h1);
    check("stale_res_frac", 32'(res_frac), 32'h3C);
    check("stale_res_err", 32'(res_err), 0);
    req      = req & ~ack;
    man_done = 1'b0;
    man_mode = 1'b0;
    @(negedge clk);

    // Reset while in WAIT; the retried request must be arbitrated from requester 0.
    stub_delay = -1;
    req = 4'b0100;
    wh = 0; early = 0; s = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack != '0) early++;
      if (cos_start) s = 1'b1;
      else if (s) begin
        wh++;
        if (wh == 5) break;
      end
    end
    check("rstwait_reached", 32'(wh), 5);
    rst = 1'b1;
    req = 4'b1100;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0;
    stub_delay = 3;
    stub_int   = 2'b10;
    stub_frac  = 8'h5A;
    wait_ack(60, lat, ns, ok);
    check("rstwait_no_abort_ack", 32'(early), 0);
    check("retry_ack", 32'(ack), 32'h4);
    check("retry_grant_id", 32'(grant_id), 2);
    check("retry_res_frac", 32'(res_frac), 32'h5A);
    check("retry_latency", 32'(lat), 4);
    req = req & ~ack;
    @(negedge clk);

    // Operand stability and withdrawn request: requester 3 is now granted.
    stub_delay = 8;
    stub_int   = 2'b11;
    stub_frac  = 8'hA5;
    seen = 1'b0; unstable = 0; hx = '0; hy = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (cos_start && !seen) begin
        seen = 1'b1;
        hx   = cos_x;
        hy   = cos_y;
      end
      if (seen) begin
        if (cos_x !== hx || cos_y !== hy) unstable++;
        req_x[39:30] = 10'($urandom);
        req_y[31:24] = 8'($urandom);
        req[3]       = 1'b0;
      end
      if (ack != '0) break;
    end
    check("stable_grant_x", 32'(hx), 32'(opx[3]));
    check("stable_grant_y", 32'(hy), 32'(opy[3]));
    check("stable_changes", 32'(unstable), 0);
    check("withdrawn_ack", 32'(ack), 32'h8);
    check("withdrawn_res_frac", 32'(res_frac), 32'hA5);
    check("withdrawn_res_err", 32'(res_err), 0);
    @(negedge clk);
    check("final_idle_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cos_scheduler.md
# cos_scheduler

Round-robin scheduler sharing one `coss` cosine unit between `N` requesters. Each requester presents an operand pair (`x`, `y`) and holds `req`. The scheduler grants one requester at a time, sequences the unit's `start`/`done` handshake, and returns the result with a one-cycle `ack`. A watchdog guarantees every grant completes, either with a result or with an error.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `START_CYCLES`, 2: cycles `cos_start` is held high per operation (≥1).
- `TIMEOUT`, 1023: max cycles in WAIT before the operation is aborted with an error.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-requester request level; held until own `ack`.
- `req_x`  in  N*10  packed operand x; slice i = `[10*i+9:10*i]`.
- `req_y`  in  N*8  packed operand y; slice i = `[8*i+7:8*i]`.
- `ack`  out  N  one-hot, one-cycle completion pulse.
- `res_int`  out  2  result integer part; valid only in the `ack` cycle.
- `res_frac`  out  8  result fractional part; valid only in the `ack` cycle.
- `res_err`  out  1  timeout flag; valid only in the `ack` cycle.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  3  index of the current or last granted requester.
- `cos_start`  out  1  to `coss` start.
- `cos_x`  out  10  to `coss` x.
- `cos_y`  out  8  to `coss` y.
- `cos_done`  in  1  from `coss` done.
- `cos_intpart`  in  2  from `coss` intpart.
- `cos_fracpart`  in  8  from `coss` fracpart.

## Operation
States:
- **IDLE**: no operation in flight.
  - If any `req` is high, grant the first requester at or after `rr_ptr` (cyclic search).
  - Latch that requester's x/y into `cos_x`/`cos_y`, set `grant_id`, set `rr_ptr = (g+1) mod N`, and go to START.
- **START**: `cos_start` = 1 for exactly `START_CYCLES` cycles, then go to WAIT.
- **WAIT**: `cos_start` = 0; the watchdog counter increments each cycle.
  - `done` is accepted only after `cos_done` has been sampled low at least once in WAIT (flag `seen_low`). This rejects a `done` level left over from the previous operation.
  - When `seen_low` is set and `cos_done` = 1: capture `cos_intpart`/`cos_fracpart`, set err = 0, go to RESP.
  - When the counter reaches `TIMEOUT`: capture 0/0, set err = 1, go to RESP.
- **RESP**: `ack[g]` = 1 and `res_*` driven from the capture registers for one cycle, then IDLE.

Rules:
- `cos_x`/`cos_y` hold their value from the grant until the next grant, so they are stable throughout START, WAIT and RESP.
- Changes to `req_x`/`req_y` after the grant are ignored.
- Withdrawn request: if `req[g]` drops after the grant, the operation still completes and `ack[g]` still pulses. The requester must ignore it.
- A requester may re-assert `req` in the cycle after its `ack`. Because `rr_ptr` has advanced, it is served after the other pending requesters.
- Only one grant is in flight at a time. `ack` is never multi-hot.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `ack` 0, `res_int` 0, `res_frac` 0, `res_err` 0, `busy` 0, `grant_id` 0, `cos_start` 0, `cos_x` 0, `cos_y` 0, `seen_low` 0, watchdog 0.
- Reset mid-operation: return to IDLE next edge and drop `cos_start` immediately. No `ack` is issued for the aborted request; the requester must retry.
- Latency:
  - `req` sampled in IDLE at cycle t.
  - `cos_start` high at cycles t+1 .. t+START_CYCLES.
  - If `done` is accepted at cycle d, `ack` is at cycle d+1.
  - Minimum request-to-`ack`: `START_CYCLES` + 3 cycles.
  - Idle gap between operations: the RESP cycle plus one IDLE cycle.
- `cos_done` high during START is ignored.
- Watchdog: cleared on entry to WAIT, saturates at `TIMEOUT`. The `TIMEOUT` value itself triggers the abort.
- All outputs are registered. There are no combinational paths from `req`/`cos_*` inputs to any output.

## Structure
- Package `cos_sched_pkg`:
  - State enum `{IDLE, START, WAIT, RESP}`.
  - Constants `X_W`=10, `Y_W`=8, `INT_W`=2, `FRAC_W`=8.
- Sub-module `rr_arbiter`:
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt`, `gnt_idx`, `any`.
  - Combinational only. `rr_ptr` stays in the top-level module.
- Top-level `cos_scheduler` contains the FSM, operand/result registers, watchdog and `START_CYCLES` counter.

## Test plan
1. **Single request.** `req[1]` with x=10'b0110000000, y=8'b10000000; stub `done` rises 20 cycles after `start` falls with intpart=2'b00, fracpart=8'h80. Expect:
   - `cos_start` high for exactly 2 cycles.
   - `ack` = 4'b0010 for one cycle with `res_frac`=8'h80 and `res_err`=0.
   - `grant_id`=1.
2. **Round-robin order.** All 4 `req` asserted together. Expect grants in order 0, 1, 2, 3, then 0 again after `req[0]` is re-asserted. `ack` is never multi-hot.
3. **Stale done.** Stub holds `done`=1 through START and into WAIT, drops it for 1 cycle, then raises it again. Expect `ack` only after the second rise; no early `ack`.
4. **Timeout.** Stub never asserts `done`. Expect `ack` exactly `TIMEOUT`+1 cycles after WAIT entry, with `res_err`=1 and results 0. The next requester is then served normally.
5. **Reset mid-WAIT.** Assert `rst` for 1 cycle during WAIT. Expect:
   - All outputs at reset values next cycle.
   - No `ack` for the aborted request.
   - A re-asserted request is granted starting from requester 0.
6. **Operand stability.** Change `req_x[g]` and `req_y[g]` every cycle after the grant. Expect `cos_x`/`cos_y` constant from the grant through RESP.
